dpll_lock_ctrl: RTL

Acquisition/lock controller for the DPLL loop. It watches the registered phase-detector up/down pulses over fixed observation windows and sequences the loop through flush, acquisition, tracking and locked states. It drives the loop-filter gain select, the loop-filter flush, and the lock/fail status. It sits beside the phase detector and loop filter, and is the only block that writes their control inputs.

---
 rtl/dpll_pkg.sv | 27 ++
 rtl/dpll_err_window.sv | 61 ++++++
 rtl/dpll_lock_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: controller state encoding and the loop-gain codes
// that the loop filter also decodes.
package dpll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ACQUIRE,
    ST_TRACK,
    ST_LOCKED,
    ST_FAIL
  } dpll_state_e;

  localparam logic [1:0] GAIN_WIDE   = 2'b10;
  localparam logic [1:0] GAIN_MID    = 2'b01;
  localparam logic [1:0] GAIN_NARROW = 2'b00;

  // Idle reports narrow gain so every output reads zero while parked.
  function automatic logic [1:0] gainOf(input dpll_state_e s);
    case (s)
      ST_FLUSH, ST_ACQUIRE, ST_FAIL: gainOf = GAIN_WIDE;
      ST_TRACK:                      gainOf = GAIN_MID;
      default:                       gainOf = GAIN_NARROW;
    endcase
  endfunction

endpackage

// File: rtl/dpll_err_window.sv
// Observation-window counter plus saturating phase-error accumulator.
// winErr_o already includes the current cycle's event, so it is the window total on winDone_o.
module dpll_err_window #(
  parameter int WIN_LEN = 256,
  parameter int ERR_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic             pdUp_i,
  input  logic             pdDn_i,
  output logic             winDone_o,
  output logic [ERR_W-1:0] winErr_o
);

  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CW-1:0]    WIN_LAST = CW'(WIN_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [CW-1:0]    winCnt_q, winCnt_d;
  logic [ERR_W-1:0] acc_q, acc_d;
  logic [ERR_W-1:0] errSum;
  logic             errEvt;
  logic             lastCycle;

  // Overlapping up/down pulses are dead-zone, not phase error.
  always_comb begin
    errEvt    = pdUp_i ^ pdDn_i;
    errSum    = (errEvt && (acc_q != ERR_MAX)) ? acc_q + ERR_W'(1) : acc_q;
    lastCycle = (winCnt_q == WIN_LAST);
    winCnt_d  = winCnt_q;
    acc_d     = acc_q;
    if (clear_i) begin
      winCnt_d = '0;
      acc_d    = '0;
    end else if (run_i) begin
      if (lastCycle) begin
        winCnt_d = '0;
        acc_d    = '0;
      end else begin
        winCnt_d = winCnt_q + CW'(1);
        acc_d    = errSum;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      winCnt_q <= '0;
      acc_q    <= '0;
    end else begin
      winCnt_q <= winCnt_d;
      acc_q    <= acc_d;
    end
  end

  assign winDone_o = run_i && !clear_i && lastCycle;
  assign winErr_o  = errSum;

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL acquisition/lock controller: sequences flush, acquisition, tracking and lock
// from per-window phase-error counts, and drives loop-filter gain, flush and status.
module dpll_lock_ctrl
  import dpll_pkg::*;
#(
  parameter int WIN_LEN     = 256,
  parameter int ERR_W       = 8,
  parameter int LOCK_THR    = 4,
  parameter int UNLOCK_THR  = 32,
  parameter int LOCK_WINS   = 4,
  parameter int ACQ_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             pdUp_i,
  input  logic             pdDn_i,
  output logic [1:0]       gainSel_o,
  output logic             loopRst_o,
  output logic             locked_o,
  output logic             acqFail_o,
  output logic [ERR_W-1:0] errCount_o
);

  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam int AW = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [GW-1:0] LOCK_WINS_C   = GW'(LOCK_WINS);
  localparam logic [AW-1:0] ACQ_TIMEOUT_C = AW'(ACQ_TIMEOUT);

  dpll_state_e      state_q, state_d;
  logic [GW-1:0]    goodCnt_q, goodCnt_d, goodNext;
  logic [AW-1:0]    acqCnt_q, acqCnt_d, acqNext;
  logic [ERR_W-1:0] errCount_q, errCount_d;
  logic             flushCnt_q, flushCnt_d;
  logic [1:0]       gainSel_q;
  logic             loopRst_q, locked_q, acqFail_q;

  logic             counting;
  logic             winDone;
  logic [ERR_W-1:0] winErr;
  logic             winGood, winBad;

  assign counting = (state_q == ST_ACQUIRE) || (state_q == ST_TRACK) || (state_q == ST_LOCKED);

  dpll_err_window #(
    .WIN_LEN (WIN_LEN),
    .ERR_W   (ERR_W)
  ) u_errWindow (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (!enable_i || !counting),
    .run_i     (counting),
    .pdUp_i    (pdUp_i),
    .pdDn_i    (pdDn_i),
    .winDone_o (winDone),
    .winErr_o  (winErr)
  );

  always_comb begin
    winGood    = int'(winErr) <= LOCK_THR;
    winBad     = int'(winErr) > UNLOCK_THR;
    goodNext   = goodCnt_q + GW'(1);
    acqNext    = acqCnt_q + AW'(1);
    state_d    = state_q;
    goodCnt_d  = goodCnt_q;
    acqCnt_d   = acqCnt_q;
    errCount_d = errCount_q;
    flushCnt_d = flushCnt_q;

    // Dropping enable beats any window-end decision taken in the same cycle.
    if (!enable_i) begin
      state_d    = ST_IDLE;
      goodCnt_d  = '0;
      acqCnt_d   = '0;
      errCount_d = '0;
      flushCnt_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_FLUSH;
          flushCnt_d = 1'b0;
        end
        ST_FLUSH: begin
          if (flushCnt_q) begin
            state_d    = ST_ACQUIRE;
            flushCnt_d = 1'b0;
          end else begin
            flushCnt_d = 1'b1;
          end
        end
        ST_ACQUIRE: begin
          if (winDone) begin
            errCount_d = winErr;
            if (winGood) begin
              goodCnt_d = GW'(1);
              state_d   = (LOCK_WINS_C == GW'(1)) ? ST_LOCKED : ST_TRACK;
            end else begin
              acqCnt_d = acqNext;
              if (acqNext == ACQ_TIMEOUT_C) state_d = ST_FAIL;
            end
          end
        end
        ST_TRACK: begin
          if (winDone) begin
            errCount_d = winErr;
            if (winGood) begin
              goodCnt_d = goodNext;
              if (goodNext == LOCK_WINS_C) state_d = ST_LOCKED;
            end else if (winBad) begin
              state_d   = ST_ACQUIRE;
              goodCnt_d = '0;
              acqCnt_d  = '0;
            end else begin
              goodCnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (winDone) begin
            errCount_d = winErr;
            if (winBad) begin
              state_d   = ST_ACQUIRE;
              goodCnt_d = '0;
              acqCnt_d  = '0;
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      goodCnt_q  <= '0;
      acqCnt_q   <= '0;
      errCount_q <= '0;
      flushCnt_q <= 1'b0;
      gainSel_q  <= GAIN_NARROW;
      loopRst_q  <= 1'b0;
      locked_q   <= 1'b0;
      acqFail_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      goodCnt_q  <= goodCnt_d;
      acqCnt_q   <= acqCnt_d;
      errCount_q <= errCount_d;
      flushCnt_q <= flushCnt_d;
      gainSel_q  <= gainOf(state_d);
      loopRst_q  <= (state_d == ST_FLUSH);
      locked_q   <= (state_d == ST_LOCKED);
      acqFail_q  <= (state_d == ST_FAIL);
    end
  end

  assign gainSel_o  = gainSel_q;
  assign loopRst_o  = loopRst_q;
  assign locked_o   = locked_q;
  assign acqFail_o  = acqFail_q;
  assign errCount_o = errCount_q;

endmodule
